inst_fetch_bridge: RTL and testbench
====================================

// Module: inst_fetch_bridge
// PURPOSE
//  Fetch-side memory bridge. Takes the PC driven by the IF PC generator and runs
//  SRAM-like read transactions (req/addr_ok/data_ok) to instruction memory.
//  Returns the fetched word to ID, plus a stall request that the hazard unit feeds back as StallF.
//  Discards responses for PCs abandoned on redirect (jump, branch, exception, EPC return).
// PARAMETERS
//  WIDTH     32        address/data width
//  NOP_INST  32'h0     word driven on inst_out for a misaligned PC
// PORTS
//  clk            in   1      system clock, rising edge
//  rst            in   1      asynchronous, active-low reset
//  pc_in          in   WIDTH  current PC from IF stage
//  inst_out       out  WIDTH  fetched instruction, valid when inst_valid=1
//  inst_valid     out  1      inst_out corresponds to pc_in
//  addr_err       out  1      pc_in[1:0]!=0 (AdEL on fetch)
//  stall_req      out  1      fetch for pc_in not complete; IF must hold PC
//  inst_req       out  1      memory request
//  inst_wr        out  1      constant 0
//  inst_size      out  2      constant 2'b10 (word)
//  inst_addr      out  WIDTH  request address
//  inst_wdata     out  WIDTH  constant 0
//  inst_addr_ok   in   1      request accepted this cycle
//  inst_data_ok   in   1      read data returned this cycle
//  inst_rdata     in   WIDTH  read data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, inst_req=0, inst_addr=0, inst_out=0, fetched_pc=0,
//    have_inst=0, stall_req=0. Late data_ok after reset is ignored (state IDLE).
//  misaligned = (pc_in[1:0]!=0). hit = have_inst && (fetched_pc==pc_in).
//  inst_valid = hit | misaligned. addr_err = misaligned. inst_out = misaligned ? NOP_INST : held word.
//  stall_req = rst && !inst_valid (combinational).
//  States:
//   IDLE:    if !misaligned && !hit: inst_addr<=pc_in, go REQ. Else stay.
//   REQ:     inst_req=1, inst_addr held stable until accepted (never withdrawn).
//            On addr_ok: go WAIT if pc_in==inst_addr, else DISCARD.
//   WAIT:    pc_in!=inst_addr at any cycle -> DISCARD (same cycle if data_ok also 1: data dropped,
//            go IDLE). On data_ok with pc_in==inst_addr: inst_out<=inst_rdata,
//            fetched_pc<=inst_addr, have_inst<=1, go IDLE.
//   DISCARD: wait data_ok, drop data, have_inst unchanged, go IDLE.
//  IDLE re-arms a request the cycle after any miss is seen, so a redirected PC issues its
//    request one cycle after DISCARD clears.
//  One outstanding transaction max. addr_ok and data_ok in same cycle never occur in REQ.
//  data_ok is accepted only in WAIT/DISCARD. data_ok in IDLE/REQ is ignored.
//  Min latency: pc_in stable at cycle 0 -> req cycle 1 (addr_ok=1) -> data_ok cycle 2 ->
//    inst_valid=1, stall_req=0 at cycle 3.
//  PC unchanged (StallF from elsewhere): hit holds, no new request, inst_out stable.
//  Address wrap 32'hFFFF_FFFC is an ordinary fetch; no arithmetic on PC inside block.
// TESTING
//  1 rst low->high, pc_in=bfc00000, addr_ok=1 on first req, rdata=24080001 next cycle ->
//    inst_addr=bfc00000 cycle 1, inst_out=24080001, inst_valid=1, stall_req=0 at cycle 3.
//  2 addr_ok held low 3 cycles -> inst_req=1 and inst_addr=bfc00000 constant all 4 cycles,
//    stall_req=1 throughout.
//  3 in WAIT, pc_in -> bfc00380, old data_ok with rdata=DEADBEEF -> DEADBEEF never on
//    inst_out with inst_valid=1. New req to bfc00380 issues. Its data is delivered.
//  4 pc_in=bfc00002 -> inst_req stays 0, addr_err=1, inst_out=00000000, inst_valid=1, stall_req=0.
//  5 after hit, pc_in held 10 cycles -> no inst_req pulses, inst_out unchanged.
//  6 rst low during WAIT, memory returns data_ok after release -> all outputs at reset values,
//    no inst_valid until a fresh transaction completes.

Source files
------------

// File: rtl/inst_fetch_bridge_if.sv
// SRAM-like instruction memory bus (req/addr_ok/data_ok) between the fetch bridge and imem.
interface inst_fetch_bridge_if #(
    parameter int WIDTH = 32
);
    logic             inst_req;
    logic             inst_wr;
    logic [1:0]       inst_size;
    logic [WIDTH-1:0] inst_addr;
    logic [WIDTH-1:0] inst_wdata;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic [WIDTH-1:0] inst_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Fetch-side bridge: turns the IF-stage PC into single-outstanding imem reads, holds the
// last fetched word, and drops responses that belong to a PC abandoned on redirect.
module inst_fetch_bridge #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  pc_in,
    output logic [WIDTH-1:0]  inst_out,
    output logic              inst_valid,
    output logic              addr_err,
    output logic              stall_req,
    inst_fetch_bridge_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t           state;
    logic             req_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] fetched_pc;
    logic             have_inst;

    logic misaligned, hit, pc_match;

    assign misaligned = (pc_in[1:0] != 2'b00);
    assign hit        = have_inst && (fetched_pc == pc_in);
    assign pc_match   = (pc_in == addr_q);

    assign inst_valid = hit | misaligned;
    assign addr_err   = misaligned;
    assign inst_out   = misaligned ? NOP_INST : word_q;
    assign stall_req  = rst && !inst_valid;

    assign mem.inst_req   = req_q;
    assign mem.inst_addr  = addr_q;
    assign mem.inst_wr    = 1'b0;
    assign mem.inst_size  = 2'b10;
    assign mem.inst_wdata = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            fetched_pc <= '0;
            have_inst  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!misaligned && !hit) begin
                        addr_q <= pc_in;
                        req_q  <= 1'b1;
                        state  <= REQ;
                    end
                end
                // Request is never withdrawn; a redirect here only decides where the reply goes.
                REQ: begin
                    if (mem.inst_addr_ok) begin
                        req_q <= 1'b0;
                        state <= pc_match ? WAIT : DISCARD;
                    end
                end
                WAIT: begin
                    if (!pc_match) begin
                        state <= mem.inst_data_ok ? IDLE : DISCARD;
                    end else if (mem.inst_data_ok) begin
                        word_q     <= mem.inst_rdata;
                        fetched_pc <= addr_q;
                        have_inst  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DISCARD: begin
                    if (mem.inst_data_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Scoreboard bench for inst_fetch_bridge: a delay-programmable imem responder, a monitor that
// pops expected {pc, word} pairs whenever a new aligned PC becomes valid, and directed scenarios.
module tb_inst_fetch_bridge;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        addr_err;
    logic        stall_req;

    inst_fetch_bridge_if #(.WIDTH(32)) bus ();

    inst_fetch_bridge #(.WIDTH(32), .NOP_INST(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .addr_err   (addr_err),
        .stall_req  (stall_req),
        .mem        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    fetch_t sb_q[$];

    int          aok_delay = 0;
    int          dok_delay = 0;
    bit          stale     = 1'b0;
    int          acnt      = 0;
    int          dcnt      = 0;
    bit          pending   = 1'b0;
    logic [31:0] paddr     = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hbfc0_0000) return 32'h2408_0001;
        return a ^ 32'h1357_9bdf;
    endfunction

    task automatic expect_fetch(input logic [31:0] a);
        fetch_t f;
        f.pc   = a;
        f.inst = mem_word(a);
        sb_q.push_back(f);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (inst_valid) got = 1'b1;
            else cyc();
        end
        chk("valid_timeout", got, 1'b1);
        chk("stall_on_hit", stall_req, 1'b0);
        cyc();
    endtask

    // Memory responder: addr_ok after aok_delay req cycles, data_ok dok_delay cycles later.
    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.inst_addr_ok = 1'b0;
            bus.inst_data_ok = 1'b0;
            if (pending) begin
                if (dcnt == 0) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = stale ? STALE : mem_word(paddr);
                    stale   = 1'b0;
                    pending = 1'b0;
                end else begin
                    dcnt--;
                end
            end else if (bus.inst_req) begin
                if (acnt == aok_delay) begin
                    bus.inst_addr_ok = 1'b1;
                    paddr   = bus.inst_addr;
                    pending = 1'b1;
                    dcnt    = dok_delay;
                    acnt    = 0;
                end else begin
                    acnt++;
                end
            end
        end
    end

    // Monitor: a new aligned PC turning valid must match the head of the scoreboard.
    initial begin
        bit          prev_ok = 1'b0;
        logic [31:0] prev_pc = '0;
        fetch_t      f;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("addr_err", addr_err, pc_in[1:0] != 2'b00);
                chk("inst_wr", bus.inst_wr, 1'b0);
                chk("inst_size", bus.inst_size, 2'b10);
                chk("inst_wdata", bus.inst_wdata, 32'h0);
                if (inst_valid && !addr_err) begin
                    chk("no_stale", inst_out == STALE, 1'b0);
                    if (!(prev_ok && prev_pc == pc_in)) begin
                        if (sb_q.size() == 0) begin
                            chk("sb_unexpected", pc_in, 32'hffff_ffff);
                        end else begin
                            f = sb_q.pop_front();
                            chk("sb_pc", pc_in, f.pc);
                            chk("sb_inst", inst_out, f.inst);
                        end
                    end
                end
                prev_ok = inst_valid && !addr_err;
                prev_pc = pc_in;
            end else begin
                prev_ok = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        pc_in = 32'hbfc0_0000;
        expect_fetch(32'hbfc0_0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_req", bus.inst_req, 1'b0);
        chk("rst_inst_addr", bus.inst_addr, 32'h0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_stall", stall_req, 1'b0);

        // Minimum-latency fetch: req in cycle 1, inst_valid in cycle 3.
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("c0_stall", stall_req, 1'b1);
        chk("c0_req", bus.inst_req, 1'b0);
        cyc(); @(negedge clk);
        chk("c1_req", bus.inst_req, 1'b1);
        chk("c1_addr", bus.inst_addr, 32'hbfc0_0000);
        cyc(); @(negedge clk);
        chk("c2_stall", stall_req, 1'b1);
        cyc(); @(negedge clk);
        chk("c3_valid", inst_valid, 1'b1);
        chk("c3_inst", inst_out, 32'h2408_0001);
        chk("c3_stall", stall_req, 1'b0);

        // addr_ok withheld: request and address stay put.
        cyc(); aok_delay = 3; pc_in = 32'h0000_1000;
        expect_fetch(32'h0000_1000);
        for (int i = 0; i < 4; i++) begin
            cyc(); @(negedge clk);
            chk("hold_req", bus.inst_req, 1'b1);
            chk("hold_addr", bus.inst_addr, 32'h0000_1000);
            chk("hold_stall", stall_req, 1'b1);
        end
        wait_valid(20);
        aok_delay = 0;

        // Redirect while in WAIT: stale data dropped, new PC fetched.
        dok_delay = 3; pc_in = 32'h0000_2000;
        cyc(); cyc(); cyc();
        stale = 1'b1; pc_in = 32'hbfc0_0380; dok_delay = 0;
        expect_fetch(32'hbfc0_0380);
        wait_valid(30);

        // Redirect while the request is still pending acceptance.
        aok_delay = 2; pc_in = 32'h0000_3000;
        cyc();
        stale = 1'b1; pc_in = 32'h0000_3004;
        expect_fetch(32'h0000_3004);
        wait_valid(30);
        aok_delay = 0;

        // PC held after a hit: no new requests, word stable.
        for (int i = 0; i < 10; i++) begin
            cyc(); @(negedge clk);
            chk("held_req", bus.inst_req, 1'b0);
            chk("held_valid", inst_valid, 1'b1);
            chk("held_inst", inst_out, mem_word(32'h0000_3004));
        end

        // Misaligned PC: NOP, AdEL, no request.
        cyc(); pc_in = 32'hbfc0_0002;
        @(negedge clk);
        chk("mis_err", addr_err, 1'b1);
        chk("mis_inst", inst_out, 32'h0);
        chk("mis_valid", inst_valid, 1'b1);
        chk("mis_stall", stall_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(); @(negedge clk);
            chk("mis_req", bus.inst_req, 1'b0);
        end

        // Top-of-address-space fetch.
        cyc(); pc_in = 32'hffff_fffc;
        expect_fetch(32'hffff_fffc);
        wait_valid(20);

        // Reset during WAIT; the old reply arrives after release and must be ignored.
        dok_delay = 4; stale = 1'b1; pc_in = 32'h0000_4000;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("wrst_req", bus.inst_req, 1'b0);
        chk("wrst_addr", bus.inst_addr, 32'h0);
        chk("wrst_inst", inst_out, 32'h0);
        chk("wrst_valid", inst_valid, 1'b0);
        chk("wrst_stall", stall_req, 1'b0);
        cyc(); rst = 1'b1; dok_delay = 0;
        expect_fetch(32'h0000_4000);
        wait_valid(30);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
